fb_access_arbiter: RTL and testbench

- Shares the single framebuffer access port between two requesters.
  - Port 0: the display refresh reader, i.e. the SSD1309 driver's `fb_re`/`fb_data_valid` interface.
  - Port 1: a pixel/graphics writer.
- Sits between both clients and the framebuffer module.
- Performs arbitration, command issue and completion tracking, plus a read timeout.
- Each client sees a private, level-based handshake.

---
 rtl/fb_access_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_fb_access_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_access_arbiter.sv
// Arbitrates the single framebuffer port between the display reader and a pixel writer.
// Optional FB_ARB_READ_PRIORITY_EN: reads win every tie instead of round-robin.
module fb_access_arbiter #(
  parameter int RD_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_req,
  input  logic [7:0] rd_xpos,
  input  logic [7:0] rd_ypos,
  input  logic       rd_mode,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       wr_req,
  input  logic [7:0] wr_xpos,
  input  logic [7:0] wr_ypos,
  input  logic       wr_mode,
  input  logic [7:0] wr_din,
  output logic       wr_ack,
  output logic       fb_re,
  output logic       fb_we,
  output logic [7:0] fb_xpos,
  output logic [7:0] fb_ypos,
  output logic       fb_mode,
  output logic [7:0] fb_din,
  input  logic [7:0] fb_dout,
  input  logic       fb_data_valid,
  input  logic       fb_busy,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_WAIT, S_RD_DONE, S_WR_ISSUE, S_WR_WAIT, S_WR_DONE
  } state_t;

  localparam logic [7:0] LP_TO = 8'(RD_TIMEOUT);

  state_t     r_state,      w_state;
  logic       r_last_grant, w_last_grant;
  logic [7:0] r_to_cnt,     w_to_cnt;
  logic       r_skip,       w_skip;
  logic       r_fb_re,      w_fb_re;
  logic       r_fb_we,      w_fb_we;
  logic [7:0] r_fb_xpos,    w_fb_xpos;
  logic [7:0] r_fb_ypos,    w_fb_ypos;
  logic       r_fb_mode,    w_fb_mode;
  logic [7:0] r_fb_din,     w_fb_din;
  logic [7:0] r_rd_data,    w_rd_data;
  logic       r_rd_valid,   w_rd_valid;
  logic       r_wr_ack,     w_wr_ack;
  logic       r_err_to,     w_err_to;
  logic       w_pick_rd;

`ifdef FB_ARB_READ_PRIORITY_EN
  assign w_pick_rd = rd_req;
`else
  // last_grant==1 means the writer went last, so the reader wins a tie
  assign w_pick_rd = rd_req && (!wr_req || r_last_grant);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_to_cnt     <= 8'd0;
      r_skip       <= 1'b0;
      r_fb_re      <= 1'b0;
      r_fb_we      <= 1'b0;
      r_fb_xpos    <= 8'd0;
      r_fb_ypos    <= 8'd0;
      r_fb_mode    <= 1'b0;
      r_fb_din     <= 8'd0;
      r_rd_data    <= 8'd0;
      r_rd_valid   <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_err_to     <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_last_grant <= w_last_grant;
      r_to_cnt     <= w_to_cnt;
      r_skip       <= w_skip;
      r_fb_re      <= w_fb_re;
      r_fb_we      <= w_fb_we;
      r_fb_xpos    <= w_fb_xpos;
      r_fb_ypos    <= w_fb_ypos;
      r_fb_mode    <= w_fb_mode;
      r_fb_din     <= w_fb_din;
      r_rd_data    <= w_rd_data;
      r_rd_valid   <= w_rd_valid;
      r_wr_ack     <= w_wr_ack;
      r_err_to     <= w_err_to;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_last_grant = r_last_grant;
    w_to_cnt     = r_to_cnt;
    w_skip       = r_skip;
    w_fb_re      = r_fb_re;
    w_fb_we      = 1'b0;
    w_fb_xpos    = r_fb_xpos;
    w_fb_ypos    = r_fb_ypos;
    w_fb_mode    = r_fb_mode;
    w_fb_din     = r_fb_din;
    w_rd_data    = r_rd_data;
    w_rd_valid   = r_rd_valid;
    w_wr_ack     = 1'b0;
    w_err_to     = r_err_to;
    case (r_state)
      S_IDLE: begin
        if (!fb_busy && (rd_req || wr_req)) begin
          if (w_pick_rd) begin
            w_fb_xpos    = rd_xpos;
            w_fb_ypos    = rd_ypos;
            w_fb_mode    = rd_mode;
            w_fb_re      = 1'b1;
            w_to_cnt     = 8'd0;
            w_last_grant = 1'b0;
            w_state      = S_RD_WAIT;
          end else begin
            w_fb_xpos    = wr_xpos;
            w_fb_ypos    = wr_ypos;
            w_fb_mode    = wr_mode;
            w_last_grant = 1'b1;
            w_state      = S_WR_ISSUE;
          end
        end
      end
      S_RD_WAIT: begin
        // data beats the timeout when both land in the same cycle
        if (fb_data_valid) begin
          w_rd_data  = fb_dout;
          w_rd_valid = 1'b1;
          w_fb_re    = 1'b0;
          w_state    = S_RD_DONE;
        end else if (r_to_cnt == LP_TO) begin
          w_rd_data  = 8'h00;
          w_rd_valid = 1'b1;
          w_fb_re    = 1'b0;
          w_err_to   = 1'b1;
          w_state    = S_RD_DONE;
        end else begin
          w_to_cnt = r_to_cnt + 8'd1;
        end
      end
      S_RD_DONE: begin
        if (!rd_req) begin
          w_rd_valid = 1'b0;
          w_state    = S_IDLE;
        end
      end
      S_WR_ISSUE: begin
        w_fb_din = wr_din;
        if (!fb_busy) begin
          w_fb_we = 1'b1;
          w_skip  = 1'b1;
          w_state = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        // framebuffer raises busy a cycle after the strobe, so ignore the first cycle
        if (r_skip) begin
          w_skip = 1'b0;
        end else if (!fb_busy) begin
          w_wr_ack = 1'b1;
          w_state  = S_WR_DONE;
        end
      end
      S_WR_DONE: begin
        if (!wr_req) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign fb_re       = r_fb_re;
  assign fb_we       = r_fb_we;
  assign fb_xpos     = r_fb_xpos;
  assign fb_ypos     = r_fb_ypos;
  assign fb_mode     = r_fb_mode;
  assign fb_din      = r_fb_din;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign wr_ack      = r_wr_ack;
  assign err_timeout = r_err_to;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a small behavioural framebuffer model.
module tb_fb_access_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       rd_req, rd_mode, wr_req, wr_mode;
  logic [7:0] rd_xpos, rd_ypos, wr_xpos, wr_ypos, wr_din;
  logic [7:0] rd_data, fb_xpos, fb_ypos, fb_din, fb_dout;
  logic       rd_valid, wr_ack, fb_re, fb_we, fb_mode, fb_data_valid, fb_busy, err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // framebuffer model: read data in the 4th fb_re cycle, 4 busy cycles after each write
  int         re_cnt = 0;
  int         busy_cnt = 0;
  int         we_cnt = 0;
  bit         rd_never = 1'b0;
  bit         force_busy = 1'b0;
  logic [7:0] rd_val = 8'h00;
  logic [7:0] cap_x = 8'h00, cap_y = 8'h00, cap_din = 8'h00;
  logic       cap_mode = 1'b1;

  assign fb_data_valid = fb_re && !rd_never && (re_cnt == 3);
  assign fb_dout       = fb_data_valid ? rd_val : 8'hEE;
  assign fb_busy       = force_busy || (busy_cnt != 0);

  always @(posedge clk) begin
    re_cnt <= fb_re ? re_cnt + 1 : 0;
    if (fb_we) begin
      busy_cnt <= 4;
      we_cnt   <= we_cnt + 1;
      cap_x    <= fb_xpos;
      cap_y    <= fb_ypos;
      cap_mode <= fb_mode;
      cap_din  <= fb_din;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  always #5 clk = ~clk;

  fb_access_arbiter #(.RD_TIMEOUT(20)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_xpos(rd_xpos), .rd_ypos(rd_ypos), .rd_mode(rd_mode),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_xpos(wr_xpos), .wr_ypos(wr_ypos), .wr_mode(wr_mode),
    .wr_din(wr_din), .wr_ack(wr_ack),
    .fb_re(fb_re), .fb_we(fb_we), .fb_xpos(fb_xpos), .fb_ypos(fb_ypos),
    .fb_mode(fb_mode), .fb_din(fb_din), .fb_dout(fb_dout),
    .fb_data_valid(fb_data_valid), .fb_busy(fb_busy), .err_timeout(err_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({fb_re, fb_we, fb_xpos, fb_ypos, fb_mode, fb_din,
                rd_data, rd_valid, wr_ack, err_timeout});
  endfunction

  // step until rd_valid; returns step index of first fb_re, of rd_valid, and fb_re cycle count
  task automatic run_rd(output int t_re, output int t_vld, output int n_re);
    t_re = -1; t_vld = -1; n_re = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (fb_re) begin
        n_re++;
        if (t_re < 0) t_re = i;
      end
      if (rd_valid) begin
        t_vld = i;
        break;
      end
    end
  endtask

  task automatic run_wr(output int t_we, output int t_ack);
    t_we = -1; t_ack = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (fb_we && t_we < 0) t_we = i;
      if (wr_ack) begin
        t_ack = i;
        break;
      end
    end
  endtask

  initial begin
    int t_re, t_vld, n_re, t_we, t_ack, we0, acks, ng;
    logic [7:0] seq, exp_seq;
    logic prev_re;

    reset = 1'b1;
    rd_req = 1'b0; rd_xpos = 8'd0; rd_ypos = 8'd0; rd_mode = 1'b0;
    wr_req = 1'b0; wr_xpos = 8'd0; wr_ypos = 8'd0; wr_mode = 1'b0; wr_din = 8'd0;
    repeat (3) step();
    chk("reset_outputs", outs(), 64'd0);
    reset = 1'b0;
    step();

    // read held off while the framebuffer reports busy
    force_busy = 1'b1;
    rd_xpos = 8'd5; rd_ypos = 8'd16; rd_mode = 1'b1; rd_req = 1'b1; rd_val = 8'hA5;
    step(); step();
    chk("busy_blocks_read", 64'(fb_re), 64'd0);
    force_busy = 1'b0;

    // lone read
    run_rd(t_re, t_vld, n_re);
    chk("rd_re_latency", 64'(t_re), 64'd1);
    chk("rd_valid_latency", 64'(t_vld), 64'd5);
    chk("rd_re_cycles", 64'(n_re), 64'd4);
    chk("rd_data", 64'(rd_data), 64'hA5);
    chk("rd_addr", 64'({fb_xpos, fb_ypos, fb_mode}), 64'({8'd5, 8'd16, 1'b1}));
    step(); step();
    chk("rd_valid_held", 64'({rd_valid, fb_re}), 64'b10);
    rd_req = 1'b0;
    step();
    chk("rd_valid_cleared", 64'(rd_valid), 64'd0);
    chk("no_timeout", 64'(err_timeout), 64'd0);
    step();

    // lone write, request lingers one cycle after the ack
    we0 = we_cnt;
    wr_xpos = 8'd10; wr_ypos = 8'd8; wr_mode = 1'b0; wr_din = 8'h3C; wr_req = 1'b1;
    run_wr(t_we, t_ack);
    chk("wr_we_latency", 64'(t_we), 64'd2);
    chk("wr_ack_latency", 64'(t_ack), 64'd8);
    chk("wr_capture", 64'({cap_x, cap_y, cap_mode, cap_din}),
        64'({8'd10, 8'd8, 1'b0, 8'h3C}));
    acks = 0;
    step();
    if (wr_ack) acks++;
    wr_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (wr_ack) acks++;
    end
    chk("wr_single_we", 64'(we_cnt - we0), 64'd1);
    chk("wr_single_ack", 64'(acks), 64'd0);

    // continuous contention: each client re-requests one cycle after completion
    seq = 8'd0; ng = 0; prev_re = 1'b0;
    rd_val = 8'h11; rd_req = 1'b1; wr_req = 1'b1;
    for (int i = 0; i < 400 && ng < 8; i++) begin
      step();
      if (fb_re && !prev_re) begin seq = {seq[6:0], 1'b1}; ng++; end
      if (fb_we) begin seq = {seq[6:0], 1'b0}; ng++; end
      prev_re = fb_re;
      if (rd_valid && rd_req) rd_req = 1'b0; else if (!rd_req) rd_req = 1'b1;
      if (wr_ack && wr_req) wr_req = 1'b0; else if (!wr_req) wr_req = 1'b1;
    end
    rd_req = 1'b0; wr_req = 1'b0;
`ifdef FB_ARB_READ_PRIORITY_EN
    exp_seq = 8'hFF;
`else
    exp_seq = 8'hAA;
`endif
    chk("grant_count", 64'(ng), 64'd8);
    chk("grant_order", 64'(seq), 64'(exp_seq));
    repeat (20) step();

    // read timeout, then a successful read keeps the sticky flag
    rd_never = 1'b1; rd_req = 1'b1;
    run_rd(t_re, t_vld, n_re);
    chk("to_valid_after_re", 64'(t_vld - t_re), 64'd21);
    chk("to_rd_data", 64'(rd_data), 64'h00);
    chk("to_err_set", 64'(err_timeout), 64'd1);
    rd_req = 1'b0; rd_never = 1'b0;
    step(); step();
    rd_val = 8'h5A; rd_req = 1'b1;
    run_rd(t_re, t_vld, n_re);
    chk("after_to_rd_data", 64'(rd_data), 64'h5A);
    chk("err_sticky", 64'(err_timeout), 64'd1);
    rd_req = 1'b0;
    step(); step();

    // reset during WR_WAIT
    wr_din = 8'h77; wr_req = 1'b1;
    step(); step(); step();
    reset = 1'b1;
    step();
    chk("reset_in_wr_wait", outs(), 64'd0);
    reset = 1'b0; wr_req = 1'b0;
    repeat (6) step();

    // reset during RD_WAIT, then a normal read straight after
    rd_never = 1'b1; rd_req = 1'b1;
    step(); step(); step();
    chk("rd_wait_active", 64'(fb_re), 64'd1);
    reset = 1'b1;
    step();
    chk("reset_in_rd_wait", outs(), 64'd0);
    reset = 1'b0; rd_never = 1'b0; rd_val = 8'hC3;
    run_rd(t_re, t_vld, n_re);
    chk("post_reset_re_latency", 64'(t_re), 64'd1);
    chk("post_reset_re_cycles", 64'(n_re), 64'd4);
    chk("post_reset_rd", 64'({rd_data, err_timeout}), 64'({8'hC3, 1'b0}));
    rd_req = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
